// File: rtl/uart_alu_core.sv
// UART calculator compute core: oversample tick generator, three-byte sequencing FSM
// and an 8-bit ALU. It collects operands A and B and an opcode, then emits one result byte.
module uart_alu_core #(
   parameter int CLK_FREQ   = 5_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int SIZEDATA   = 8,
   parameter int SIZEOP     = 6
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_rx_done,
   input  logic [SIZEDATA-1:0] i_rx_data,
   output logic                o_tick,
   output logic [SIZEDATA-1:0] o_tx_result,
   output logic                o_tx_signal
);

   localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(6'b100000);
   localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(6'b100010);
   localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(6'b100100);
   localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(6'b100101);
   localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(6'b100110);
   localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(6'b100111);
   localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(6'b000011);
   localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(6'b000010);

   typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, SEND} state_t;

   state_t              state;
   logic [CNT_W-1:0]    tick_cnt;
   logic                rx_prev;
   logic                accept;
   logic [SIZEDATA-1:0] a_reg;
   logic [SIZEDATA-1:0] b_reg;
   logic [SIZEOP-1:0]   op_reg;
   logic [SIZEDATA-1:0] alu_result;

   // o_tick is the registered image of the wrap condition, so the first pulse
   // appears DIVISOR clocks after reset release and then every DIVISOR clocks.
   always_ff @(posedge i_clock) begin
      // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
      // branch rather than in the sensitivity list.
      if (i_reset) begin
         tick_cnt <= '0;
         o_tick   <= 1'b0;
      end else begin
         o_tick <= (tick_cnt == CNT_W'(DIVISOR - 1));
         if (tick_cnt == CNT_W'(DIVISOR - 1)) tick_cnt <= '0;
         else                                 tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // A level held high on i_rx_done is accepted only on its first cycle.
   assign accept = i_rx_done && !rx_prev;

   always_comb begin
      // NOTE: default first so every path assigns the result and no latch is inferred.
      alu_result = '0;
      case (op_reg)
         OP_ADD:  alu_result = a_reg + b_reg;
         OP_SUB:  alu_result = a_reg - b_reg;
         OP_AND:  alu_result = a_reg & b_reg;
         OP_OR:   alu_result = a_reg | b_reg;
         OP_XOR:  alu_result = a_reg ^ b_reg;
         OP_NOR:  alu_result = ~(a_reg | b_reg);
         OP_SRA:  alu_result = $signed(a_reg) >>> b_reg;
         OP_SRL:  alu_result = a_reg >> b_reg;
         default: alu_result = '0;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= WAIT_A;
         rx_prev     <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         op_reg      <= '0;
         o_tx_result <= '0;
         o_tx_signal <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rx_prev     <= i_rx_done;
         o_tx_signal <= 1'b0;
         case (state)
            WAIT_A: if (accept) begin
               a_reg <= i_rx_data;
               state <= WAIT_B;
            end
            WAIT_B: if (accept) begin
               b_reg <= i_rx_data;
               state <= WAIT_OP;
            end
            WAIT_OP: if (accept) begin
               op_reg <= i_rx_data[SIZEOP-1:0];
               state  <= SEND;
            end
            SEND: begin
               o_tx_result <= alu_result;
               o_tx_signal <= 1'b1;
               state       <= WAIT_A;
            end
            default: state <= WAIT_A;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_core.sv
// Directed bench for uart_alu_core: tick timing, ALU opcodes through the byte
// sequence, held-level byte acceptance and mid-sequence reset.
module tb_uart_alu_core;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_rx_done = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       o_tick;
   logic [7:0] o_tx_result;
   logic       o_tx_signal;

   int checks = 0;
   int errors = 0;

   uart_alu_core dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_rx_done   (i_rx_done),
      .i_rx_data   (i_rx_data),
      .o_tick      (o_tick),
      .o_tx_result (o_tx_result),
      .o_tx_signal (o_tx_signal)
   );

   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge i_clock);
      #1;
   endtask

   // Present one operand byte with i_rx_done high for hold cycles, then idle two cycles.
   task automatic send_byte(input logic [7:0] data, input int hold);
      i_rx_data = data;
      i_rx_done = 1'b1;
      for (int c = 1; c <= hold; c++) begin
         tick_clk();
         check("no_strobe_operand", o_tx_signal, 1'b0);
      end
      i_rx_done = 1'b0;
      repeat (2) tick_clk();
   endtask

   // Opcode byte: strobe must be low after the accepting edge, high with the
   // result one edge later, and low again the edge after that.
   task automatic send_op(input string tag, input logic [7:0] op, input logic [7:0] exp, input int hold);
      int last;
      last = (hold > 3) ? hold : 3;
      i_rx_data = op;
      i_rx_done = 1'b1;
      for (int c = 1; c <= last; c++) begin
         tick_clk();
         if (c == hold) i_rx_done = 1'b0;
         if (c == 1) check({tag, "_strobe_pre"}, o_tx_signal, 1'b0);
         if (c == 2) begin
            check({tag, "_strobe"}, o_tx_signal, 1'b1);
            check({tag, "_result"}, o_tx_result, exp);
         end
         if (c >= 3) check({tag, "_strobe_post"}, o_tx_signal, 1'b0);
      end
      i_rx_done = 1'b0;
      repeat (2) tick_clk();
      check({tag, "_result_hold"}, o_tx_result, exp);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp, input int hold);
      send_byte(a, hold);
      send_byte(b, hold);
      send_op(tag, op, exp, hold);
   endtask

   initial begin
      int tick_count;
      int first_tick;

      // Reset state and tick timing; the last edge sampling reset=1 is clock 0.
      repeat (3) @(posedge i_clock);
      #1;
      check("rst_tick", o_tick, 1'b0);
      check("rst_result", o_tx_result, 8'h00);
      check("rst_strobe", o_tx_signal, 1'b0);
      i_reset = 1'b0;
      tick_count = 0;
      first_tick = -1;
      for (int k = 1; k <= 100; k++) begin
         tick_clk();
         check("tick_pattern", o_tick, ((k % 32) == 0) ? 1'b1 : 1'b0);
         if (o_tick) begin
            tick_count++;
            if (first_tick < 0) first_tick = k;
         end
      end
      check("tick_count", tick_count, 3);
      check("tick_first", first_tick, 32);
      check("idle_result", o_tx_result, 8'h00);
      check("idle_strobe", o_tx_signal, 1'b0);

      // ALU through the byte sequence with 1-clock pulses on i_rx_done.
      run_op("add",      8'h02, 8'h04, 8'h20, 8'h06, 1);
      run_op("sub",      8'h02, 8'h04, 8'h22, 8'hFE, 1);
      run_op("and",      8'h0C, 8'h0A, 8'h24, 8'h08, 1);
      run_op("or",       8'h0C, 8'h0A, 8'h25, 8'h0E, 1);
      run_op("xor",      8'h0C, 8'h0A, 8'h26, 8'h06, 1);
      run_op("nor",      8'h0C, 8'h0A, 8'h27, 8'hF1, 1);
      run_op("sra",      8'h80, 8'h01, 8'h03, 8'hC0, 1);
      run_op("srl",      8'h80, 8'h01, 8'h02, 8'h40, 1);
      run_op("sra_big",  8'h80, 8'h09, 8'h03, 8'hFF, 1);
      run_op("srl_big",  8'h80, 8'h09, 8'h02, 8'h00, 1);
      run_op("add_wrap", 8'hFF, 8'h02, 8'h20, 8'h01, 1);
      run_op("op_high",  8'h03, 8'h05, 8'hE0, 8'h08, 1);
      run_op("add2",     8'h10, 8'h01, 8'h20, 8'h11, 1);
      run_op("bad_op",   8'h10, 8'h01, 8'h3F, 8'h00, 1);

      // Level held 10 clocks per byte must be accepted once per byte.
      run_op("add_hold", 8'h02, 8'h04, 8'h20, 8'h06, 10);

      // Reset mid-sequence drops the partial operands.
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      i_reset = 1'b1;
      tick_clk();
      check("midrst_result", o_tx_result, 8'h00);
      check("midrst_strobe", o_tx_signal, 1'b0);
      i_reset = 1'b0;
      tick_clk();
      run_op("after_rst", 8'h05, 8'h03, 8'h20, 8'h08, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
